// File: rtl/fifo_1r1w.sv
// Synchronous 1R1W FIFO with registered read data (one-cycle read latency).
// Define FIFO_1R1W_ERR_FLAGS_EN to add sticky o_overflow/o_underflow outputs.
module fifo_1r1w #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned DEPTH  = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  output logic                       o_full,
  input  logic [DWIDTH-1:0]          i_wdata,
  input  logic                       i_pop,
  output logic                       o_empty,
  output logic [DWIDTH-1:0]          o_rdata,
  output logic                       o_rvalid,
  output logic [$clog2(DEPTH+1)-1:0] o_count
`ifdef FIFO_1R1W_ERR_FLAGS_EN
  ,
  output logic                       o_overflow,
  output logic                       o_underflow
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign o_full  = (o_count == CW'(DEPTH));
  assign o_empty = (o_count == '0);
  assign push_ok = i_push && !o_full;
  assign pop_ok  = i_pop && !o_empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem[wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      o_count  <= '0;
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= pop_ok;
      if (push_ok) begin
        // Explicit wrap keeps non-power-of-two depths correct.
        if (wr_ptr == PW'(DEPTH-1)) wr_ptr <= '0;
        else                        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        o_rdata <= mem[rd_ptr];
        if (rd_ptr == PW'(DEPTH-1)) rd_ptr <= '0;
        else                        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push_ok, pop_ok})
        2'b10:   o_count <= o_count + 1'b1;
        2'b01:   o_count <= o_count - 1'b1;
        default: o_count <= o_count;
      endcase
    end
  end

`ifdef FIFO_1R1W_ERR_FLAGS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_push && o_full)  o_overflow  <= 1'b1;
      if (i_pop  && o_empty) o_underflow <= 1'b1;
    end
  end
`endif

endmodule
